// File: rtl/muxn_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muxn_stage : N-way W-bit operand selector, registered output, with direct
//              load and a valid/ready sequencer that steps through channels.
// Rev 1.0
// ---------------------------------------------------------------------------
module muxn_stage #(
  parameter int             W         = 32,
  parameter int             N         = 3,
  parameter int             SW        = 2,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N*W-1:0]   in_bus,
  input  logic [SW-1:0]    sel,
  input  logic             ld,
  input  logic             seq_start,
  input  logic             ready,
  input  logic             err_clr,
  output logic [W-1:0]     out,
  output logic             out_valid,
  output logic             last,
  output logic             busy,
  output logic             sel_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

  localparam logic [SW-1:0] C_LAST_IDX = SW'(N - 1);

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_idx, w_idx_nxt;
  logic [W-1:0]    r_out, w_out_nxt;
  logic            r_out_valid, w_out_valid_nxt;
  logic            r_last, w_last_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_sel_err, w_sel_err_nxt;
  logic            w_err_set;
  logic [SW-1:0]   w_pick_idx;
  logic [W-1:0]    w_pick_data;

  // One shared channel mux serves both direct loads and sequence beats.
  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick_idx == SW'(i)) begin
        w_pick_data = in_bus[i*W +: W];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_out_nxt       = r_out;
    w_out_valid_nxt = r_out_valid;
    w_last_nxt      = r_last;
    w_busy_nxt      = r_busy;
    w_err_set       = 1'b0;
    w_pick_idx      = r_idx + 1'b1;

    case (r_state)
      ST_IDLE: begin
        w_out_valid_nxt = 1'b0;
        w_last_nxt      = 1'b0;
        w_busy_nxt      = 1'b0;
        w_pick_idx      = seq_start ? '0 : sel;
        if (seq_start) begin
          w_out_nxt       = w_pick_data;
          w_idx_nxt       = '0;
          w_out_valid_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
          w_last_nxt      = (N == 1);
          w_state_nxt     = ST_SEQ;
        end else if (ld) begin
          if (sel > C_LAST_IDX) begin
            w_err_set = 1'b1;
          end else begin
            w_out_nxt       = w_pick_data;
            w_out_valid_nxt = 1'b1;
          end
        end
      end

      ST_SEQ: begin
        if (ready) begin
          if (r_idx != C_LAST_IDX) begin
            w_idx_nxt       = r_idx + 1'b1;
            w_out_nxt       = w_pick_data;
            w_out_valid_nxt = 1'b1;
            w_last_nxt      = ((r_idx + 1'b1) == C_LAST_IDX);
          end else begin
            w_out_valid_nxt = 1'b0;
            w_last_nxt      = 1'b0;
            w_busy_nxt      = 1'b0;
            w_state_nxt     = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A new error outranks a simultaneous clear.
    w_sel_err_nxt = w_err_set ? 1'b1 : (err_clr ? 1'b0 : r_sel_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_out       <= RESET_VAL;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_last      <= w_last_nxt;
      r_busy      <= w_busy_nxt;
      r_sel_err   <= w_sel_err_nxt;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign last      = r_last;
  assign busy      = r_busy;
  assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_muxn_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muxn_stage : vector table, hand sequences and random run against a
//                 queue-based reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_muxn_stage;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N*W-1:0]   in_bus;
  logic [SW-1:0]    sel;
  logic             ld, seq_start, ready, err_clr;
  logic [W-1:0]     out;
  logic             out_valid, last, busy, sel_err;

  muxn_stage #(.W(W), .N(N), .SW(SW), .RESET_VAL('0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_bus    (in_bus),
    .sel       (sel),
    .ld        (ld),
    .seq_start (seq_start),
    .ready     (ready),
    .err_clr   (err_clr),
    .out       (out),
    .out_valid (out_valid),
    .last      (last),
    .busy      (busy),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e_out, input logic e_v,
                           input logic e_l, input logic e_b, input logic e_e);
    check({tag, " out"},       64'(out),       64'(e_out));
    check({tag, " out_valid"}, 64'(out_valid), 64'(e_v));
    check({tag, " last"},      64'(last),      64'(e_l));
    check({tag, " busy"},      64'(busy),      64'(e_b));
    check({tag, " sel_err"},   64'(sel_err),   64'(e_e));
  endtask

  typedef struct {
    logic           ld;
    logic [SW-1:0]  sel;
    logic           seq;
    logic           rdy;
    logic           clr;
    logic [N*W-1:0] bus;
    logic [W-1:0]   e_out;
    logic           e_v, e_l, e_b, e_e;
  } vec_t;

  function automatic vec_t mk(logic l, logic [SW-1:0] s, logic sq, logic r, logic c,
                              logic [N*W-1:0] b, logic [W-1:0] eo,
                              logic ev, logic el, logic eb, logic ee);
    vec_t v;
    v.ld = l; v.sel = s; v.seq = sq; v.rdy = r; v.clr = c; v.bus = b;
    v.e_out = eo; v.e_v = ev; v.e_l = el; v.e_b = eb; v.e_e = ee;
    return v;
  endfunction

  // Reference model: a sequence is a queue of channel indices still to send.
  logic [W-1:0] m_out;
  logic         m_valid, m_last, m_busy, m_err;
  int           m_rem[$];

  function automatic logic [W-1:0] chan(int i);
    logic [N*W-1:0] t;
    t = in_bus >> (i * W);
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    m_out = '0; m_valid = 0; m_last = 0; m_busy = 0; m_err = 0;
    m_rem.delete();
  endtask

  task automatic model_step();
    logic set_err;
    int   c;
    set_err = 0;
    if (m_busy) begin
      if (ready) begin
        if (m_rem.size() > 0) begin
          c      = m_rem.pop_front();
          m_out  = chan(c);
          m_last = (m_rem.size() == 0);
        end else begin
          m_busy = 0; m_valid = 0; m_last = 0;
        end
      end
    end else begin
      m_valid = 0; m_last = 0;
      if (seq_start) begin
        m_rem.delete();
        for (int i = 1; i < N; i++) m_rem.push_back(i);
        m_out = chan(0); m_valid = 1; m_busy = 1;
        m_last = (m_rem.size() == 0);
      end else if (ld) begin
        if (int'(sel) < N) begin
          m_out = chan(int'(sel)); m_valid = 1;
        end else begin
          set_err = 1;
        end
      end
    end
    if (set_err) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  vec_t tbl[$];
  localparam logic [N*W-1:0] BUS_A = {32'h33, 32'h22, 32'h11};
  localparam logic [N*W-1:0] BUS_B = {32'h33, 32'hAA, 32'h11};

  initial begin
    reset_n = 0; in_bus = BUS_A; sel = '0;
    ld = 0; seq_start = 0; ready = 0; err_clr = 0;

    //          ld sel sq rdy clr bus    out     v  l  b  e
    tbl.push_back(mk(1, 2, 0, 0, 0, BUS_A, 32'h33, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, BUS_A, 32'h33, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, BUS_A, 32'h22, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 0, BUS_A, 32'h22, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3, 0, 0, 1, BUS_A, 32'h22, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, BUS_A, 32'h22, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, BUS_A, 32'h11, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, BUS_A, 32'h22, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, BUS_A, 32'h33, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, BUS_A, 32'h33, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 1, 0, 0, BUS_A, 32'h11, 1, 0, 1, 0));
    tbl.push_back(mk(1, 2, 0, 1, 0, BUS_A, 32'h22, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, BUS_B, 32'h22, 1, 0, 1, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, BUS_B, 32'h22, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, BUS_B, 32'h22, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, BUS_B, 32'h33, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, BUS_B, 32'h33, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, BUS_B, 32'h11, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, BUS_B, 32'hAA, 1, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1;

    for (int k = 0; k < tbl.size(); k++) begin
      ld = tbl[k].ld; sel = tbl[k].sel; seq_start = tbl[k].seq;
      ready = tbl[k].rdy; err_clr = tbl[k].clr; in_bus = tbl[k].bus;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", k), tbl[k].e_out, tbl[k].e_v, tbl[k].e_l,
                tbl[k].e_b, tbl[k].e_e);
    end

    // Mid-sequence asynchronous reset, then restart from channel 0.
    ld = 0; err_clr = 0; in_bus = BUS_A; seq_start = 1; ready = 1;
    @(posedge clk); #1;
    check_all("mrst beat1", 32'h11, 1, 0, 1, 0);
    seq_start = 0;
    @(posedge clk); #1;
    check_all("mrst beat2", 32'h22, 1, 0, 1, 0);
    reset_n = 0;
    #1;
    check_all("mrst async", 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1; seq_start = 1; ready = 0;
    @(posedge clk); #1;
    check_all("mrst restart", 32'h11, 1, 0, 1, 0);
    seq_start = 0;
    @(posedge clk); #1;
    check_all("mrst no replay", 32'h11, 1, 0, 1, 0);

    // Randomised run from a clean reset against the reference model.
    reset_n = 0; ready = 0;
    #2;
    model_reset();
    @(negedge clk);
    reset_n = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      ld        = ($urandom_range(0, 9) < 3);
      seq_start = ($urandom_range(0, 9) < 1);
      ready     = ($urandom_range(0, 9) < 6);
      err_clr   = ($urandom_range(0, 9) < 1);
      sel       = SW'($urandom_range(0, 3));
      in_bus    = {$urandom, $urandom, $urandom};
      @(posedge clk);
      model_step();
      #1;
      check_all($sformatf("rand%0d", cyc), m_out, m_valid, m_last, m_busy, m_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
